// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int SCW = 4;
  localparam int CW = $clog2(4);
endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// lat_counter: loadable down-counter that flags when the memory read latency has elapsed
module lat_counter #(
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] ld_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt <= '0;
    else if (load) cnt <= ld_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports,
// data first but with a bound on consecutive data grants while a fetch waits
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WL   = 32,
  parameter int AWL  = 9,
  parameter int LAT  = 1,
  parameter int MAXD = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           IReq,
  input  logic [AWL-1:0] IAddr,
  output logic           IAck,
  output logic [WL-1:0]  IRData,
  input  logic           DReq,
  input  logic           DWE,
  input  logic [AWL-1:0] DAddr,
  input  logic [WL-1:0]  DWData,
  output logic           DAck,
  output logic [WL-1:0]  DRData,
  output logic           StallI,
  output logic           StallD,
  output logic           MEn,
  output logic           MWE,
  output logic [AWL-1:0] MAddr,
  output logic [WL-1:0]  MWData,
  input  logic [WL-1:0]  MRData
);
  state_t         st;
  logic           own;
  logic [SCW-1:0] starve;
  logic           gnt_d;
  logic           cnt_zero;
  assign gnt_d  = DReq & (~IReq | (starve != SCW'(MAXD)));
  assign StallI = IReq & ~IAck;
  assign StallD = DReq & ~DAck;
  lat_counter #(.W(CW)) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .load  (st == ISSUE),
    .dec   (st == WAIT),
    .ld_val(CW'(LAT - 1)),
    .zero  (cnt_zero)
  );
  // MEn is raised on the grant edge so it is high for exactly the ISSUE cycle
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      st     <= IDLE;
      own    <= OWN_I;
      starve <= '0;
      MEn    <= 1'b0;
      MWE    <= 1'b0;
      MAddr  <= '0;
      MWData <= '0;
      IAck   <= 1'b0;
      DAck   <= 1'b0;
      IRData <= '0;
      DRData <= '0;
    end else begin
      MEn  <= 1'b0;
      IAck <= 1'b0;
      DAck <= 1'b0;
      case (st)
        IDLE:
          if (IReq | DReq) begin
            st     <= ISSUE;
            own    <= gnt_d ? OWN_D : OWN_I;
            MEn    <= 1'b1;
            MAddr  <= gnt_d ? DAddr : IAddr;
            MWE    <= gnt_d & DWE;
            MWData <= gnt_d ? DWData : MWData;
            starve <= gnt_d ? starve + SCW'(IReq) : '0;
          end
        ISSUE: st <= WAIT;
        WAIT:
          if (cnt_zero) begin
            st   <= DONE;
            IAck <= own == OWN_I;
            DAck <= own == OWN_D;
            if (own == OWN_I) IRData <= MRData;
            else if (!MWE) DRData <= MRData;
          end
        default: st <= IDLE;
      endcase
    end
endmodule
